// File: rtl/ro_trng_pkg.sv
// Shared types and default sizes for the ring-oscillator TRNG slice.
package ro_trng_pkg;

    localparam int unsigned NUM_RO_DEF = 32;
    localparam int unsigned SEL_W_DEF  = 5;
    localparam int unsigned WORD_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        STALL
    } ro_state_e;

endpackage

// File: rtl/ro_bit_sync.sv
// Two-flop synchronizer bringing the asynchronous ring-oscillator output into the clk domain.
module ro_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/ro_entropy_sequencer.sv
// Round-robin RO sequencer: settle, XOR-fold samples into raw bits, pack into words on valid/ready.
// Optional von Neumann debiasing of raw bits when RO_VN_DEBIAS_EN is defined.
module ro_entropy_sequencer
    import ro_trng_pkg::*;
#(
    parameter int unsigned NUM_RO     = NUM_RO_DEF,
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned SAMPLE_CYC = 8,
    parameter int unsigned WORD_W     = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              ro_bit,
    output logic [NUM_RO-1:0] ro_en_n,
    output logic [SEL_W-1:0]  ro_sel,
    output logic              busy,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BCNT_W  = $clog2(WORD_W);

    ro_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              acc_q, acc_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ro_sync;
    logic              raw_bit;
    logic              new_bit;
    logic              accept;
`ifdef RO_VN_DEBIAS_EN
    logic              pair_full_q, pair_full_d;
    logic              pair_bit_q, pair_bit_d;
`endif

    ro_bit_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ro_bit),
        .sync_o  (ro_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        valid_d = valid_q & ~rnd_ready;
        raw_bit = acc_q ^ ro_sync;
        new_bit = raw_bit;
        accept  = 1'b0;
`ifdef RO_VN_DEBIAS_EN
        pair_full_d = pair_full_q;
        pair_bit_d  = pair_bit_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                acc_d = raw_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = run ? SETTLE : IDLE;
`ifdef RO_VN_DEBIAS_EN
                    // First raw bit of a pair is only latched; the second decides.
                    if (!pair_full_q) begin
                        pair_full_d = 1'b1;
                        pair_bit_d  = raw_bit;
                    end else begin
                        pair_full_d = 1'b0;
                        accept      = pair_bit_q ^ raw_bit;
                        new_bit     = pair_bit_q;
                    end
`else
                    accept = 1'b1;
`endif
                    if (accept) begin
                        shreg_d = {shreg_q[WORD_W-2:0], new_bit};
                        if (bcnt_q == BCNT_W'(WORD_W - 1)) begin
                            bcnt_d = '0;
                            if (!valid_q || rnd_ready) begin
                                data_d  = shreg_d;
                                valid_d = 1'b1;
                            end else begin
                                state_d = STALL;
                            end
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end
                end
            end
            STALL: begin
                // Completed word waits in shreg_q until the output register drains.
                if (rnd_ready) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    state_d = run ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            acc_q   <= 1'b0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef RO_VN_DEBIAS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_full_q <= 1'b0;
            pair_bit_q  <= 1'b0;
        end else begin
            pair_full_q <= pair_full_d;
            pair_bit_q  <= pair_bit_d;
        end
    end
`endif

    assign ro_en_n   = (state_q == SETTLE || state_q == SAMPLE) ? ~(NUM_RO'(1) << sel_q) : '1;
    assign ro_sel    = sel_q;
    assign busy      = (state_q != IDLE);
    assign rnd_data  = data_q;
    assign rnd_valid = valid_q;

endmodule

// File: tb/tb_ro_entropy_sequencer.sv
// Scoreboard bench for ro_entropy_sequencer (default build, SETTLE_CYC=4, SAMPLE_CYC=2, WORD_W=8).
module tb_ro_entropy_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        ro_bit = 1'b1;
    logic [31:0] ro_en_n;
    logic [4:0]  ro_sel;
    logic        busy;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        rnd_ready = 1'b1;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [4:0]  exp_sel = '0;
    bit          tog_mode = 1'b0;

    ro_entropy_sequencer #(
        .NUM_RO     (32),
        .SEL_W      (5),
        .SETTLE_CYC (4),
        .SAMPLE_CYC (2),
        .WORD_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .ro_bit    (ro_bit),
        .ro_en_n   (ro_en_n),
        .ro_sel    (ro_sel),
        .busy      (busy),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready)
    );

    always #5 clk = ~clk;

    // Toggling every cycle makes both folded samples differ (raw 1); constant gives raw 0.
    always @(negedge clk) ro_bit = tog_mode ? ~ro_bit : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b, input bit drop);
        bit ok;
        tog_mode = b;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (ro_en_n[exp_sel] === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        check("enable_timeout", 32'(ok), 32'd1);
        check("ro_sel", 32'(ro_sel), 32'(exp_sel));
        check("ro_en_n", ro_en_n, ~(32'd1 << exp_sel));
        if (drop) begin
            @(negedge clk);
            run = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (ro_sel !== exp_sel) ok = 1'b1;
            else @(negedge clk);
        end
        check("boundary_timeout", 32'(ok), 32'd1);
        exp_sel = exp_sel + 5'd1;
    endtask

    task automatic send_word(input logic [7:0] w);
        exp_q.push_back(w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ro_en_n", ro_en_n, 32'hFFFF_FFFF);
        check("rst_rnd_valid", 32'(rnd_valid), 32'd0);
        check("rst_ro_sel", 32'(ro_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rnd_data", 32'(rnd_data), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks bank-enable sanity each cycle.
    initial begin
        logic [7:0] exp_w;
        bit         bank_ok;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                bank_ok = (ro_en_n == 32'hFFFF_FFFF) ||
                          ((ro_en_n == ~(32'd1 << ro_sel)) && busy);
                check("bank_enable", 32'(bank_ok), 32'd1);
                check("no_x", 32'($isunknown({ro_en_n, ro_sel, busy, rnd_data, rnd_valid})), 32'd0);
                if (rnd_valid && rnd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", 32'(rnd_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("rnd_data", 32'(rnd_data), 32'(exp_w));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check_reset_outputs();

        // Reset asserted mid-SAMPLE must abort the bit in progress.
        rst = 1'b0;
        run = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // Constant ro_bit: every fold is 0.
        exp_sel = '0;
        run = 1'b1;
        send_word(8'h00);

        // Mixed patterns.
        send_word(8'hA5);
        send_word(8'h3C);

        // All-ones word across sel 24..31, held in the output register.
        exp_q.push_back(8'hFF);
        send_bit(1'b1, 1'b0);
        rnd_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);

        // Next word wraps sel to 0..7 and must stall behind the undrained one.
        send_word(8'h69);
        check("stall_ro_en_n", ro_en_n, 32'hFFFF_FFFF);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_rnd_valid", 32'(rnd_valid), 32'd1);
        check("stall_rnd_data", 32'(rnd_data), 32'hFF);
        repeat (3) @(negedge clk);
        check("stall_hold_ro_en_n", ro_en_n, 32'hFFFF_FFFF);
        check("stall_hold_rnd_data", 32'(rnd_data), 32'hFF);
        rnd_ready = 1'b1;
        @(negedge clk);
        check("unstall_rnd_valid", 32'(rnd_valid), 32'd1);
        check("unstall_ro_en_n", ro_en_n, ~(32'd1 << 8));

        // run dropped mid-SETTLE of the 4th bit: bit completes, then IDLE, word resumes later.
        exp_q.push_back(8'hB2);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_ro_en_n", ro_en_n, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rnd_valid", 32'(rnd_valid), 32'd0);
        check("idle_ro_sel", 32'(ro_sel), 32'd12);
        run = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);

        run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (busy === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        check("final_idle_timeout", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
